rcn_master_ordered: RTL and testbench

- Ordering front-end that sits directly upstream of the buffered rcn master.
- Accepts simple valid/ready requests and allocates the 2-bit seq tag for each one.
- Tracks up to 4 outstanding transactions.
- Captures responses, which may return out of order by seq, and returns them to the requester strictly in issue order over a valid/ready response channel.

---
 rtl/rcn_master_ordered.sv | 153 +++++++++++++++
 tb/tb_rcn_master_ordered.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rcn_master_ordered.sv
// Ordering front-end for the buffered rcn master: allocates seq tags, parks
// out-of-order responses per tag, and hands them back strictly in issue order.
package rcn_master_ordered_pkg;
    typedef struct packed {
        logic        wr;
        logic [3:0]  mask;
        logic [23:0] addr;
        logic [31:0] data;
    } rsp_ent_t;
endpackage

module rcn_ordered_slot
    import rcn_master_ordered_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     alloc,
    input  logic     retire,
    input  logic     capture,
    input  rsp_ent_t cap_ent,
    output logic     busy,
    output logic     done,
    output rsp_ent_t ent
);
    // Retire clears first so an allocation of the same index in the same
    // cycle leaves the slot busy for the new transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
            ent  <= '0;
        end else begin
            if (retire) begin
                busy <= 1'b0;
                done <= 1'b0;
            end
            if (alloc) begin
                busy <= 1'b1;
                done <= 1'b0;
            end
            if (capture) begin
                done <= 1'b1;
                ent  <= cap_ent;
            end
        end
    end
endmodule

module rcn_master_ordered
    import rcn_master_ordered_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_vld,
    output logic        req_rdy,
    input  logic        req_wr,
    input  logic [3:0]  req_mask,
    input  logic [23:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_vld,
    input  logic        rsp_rdy,
    output logic        rsp_wr,
    output logic [3:0]  rsp_mask,
    output logic [23:0] rsp_addr,
    output logic [31:0] rsp_data,
    output logic [2:0]  outstanding,
    output logic        stray_err,
    output logic        mst_cs,
    output logic [1:0]  mst_seq,
    input  logic        mst_busy,
    output logic        mst_wr,
    output logic [3:0]  mst_mask,
    output logic [23:0] mst_addr,
    output logic [31:0] mst_wdata,
    input  logic        mst_rdone,
    input  logic        mst_wdone,
    input  logic [1:0]  mst_rsp_seq,
    input  logic [3:0]  mst_rsp_mask,
    input  logic [23:0] mst_rsp_addr,
    input  logic [31:0] mst_rsp_data
);
    localparam int NUM_SLOTS = 4;

    logic [1:0]           alloc_ptr, ret_ptr;
    logic [2:0]           cnt;
    logic [NUM_SLOTS-1:0] slot_busy, slot_done;
    rsp_ent_t             slot_ent [NUM_SLOTS];
    rsp_ent_t             cap_ent, ret_ent;
    logic                 full, issue, retire, rsp_strobe, capture;

    assign full    = cnt >= 3'(MAX_OUTSTANDING);
    assign mst_cs  = req_vld && !full;
    assign req_rdy = !full && !mst_busy;
    assign issue   = req_vld && req_rdy;

    assign mst_seq   = alloc_ptr;
    assign mst_wr    = req_wr;
    assign mst_mask  = req_mask;
    assign mst_addr  = req_addr;
    assign mst_wdata = req_wdata;

    // A simultaneous rdone+wdone is one response, tagged as a write.
    assign rsp_strobe = mst_rdone || mst_wdone;
    assign capture    = rsp_strobe && slot_busy[mst_rsp_seq] && !slot_done[mst_rsp_seq];
    assign cap_ent    = '{wr: mst_wdone, mask: mst_rsp_mask, addr: mst_rsp_addr, data: mst_rsp_data};

    assign rsp_vld  = slot_done[ret_ptr];
    assign retire   = rsp_vld && rsp_rdy;
    assign ret_ent  = slot_ent[ret_ptr];
    assign rsp_wr   = ret_ent.wr;
    assign rsp_mask = ret_ent.mask;
    assign rsp_addr = ret_ent.addr;
    assign rsp_data = ret_ent.data;

    assign outstanding = cnt;

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
        rcn_ordered_slot u_slot (
            .clk     (clk),
            .rst     (rst),
            .alloc   (issue && (alloc_ptr == 2'(g))),
            .retire  (retire && (ret_ptr == 2'(g))),
            .capture (capture && (mst_rsp_seq == 2'(g))),
            .cap_ent (cap_ent),
            .busy    (slot_busy[g]),
            .done    (slot_done[g]),
            .ent     (slot_ent[g])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alloc_ptr <= 2'd0;
            ret_ptr   <= 2'd0;
            cnt       <= 3'd0;
            stray_err <= 1'b0;
        end else begin
            if (issue)
                alloc_ptr <= alloc_ptr + 2'd1;
            if (retire)
                ret_ptr <= ret_ptr + 2'd1;
            case ({issue, retire})
                2'b10:   cnt <= cnt + 3'd1;
                2'b01:   cnt <= cnt - 3'd1;
                default: cnt <= cnt;
            endcase
            if (rsp_strobe && !capture)
                stray_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_rcn_master_ordered.sv
// Bench for rcn_master_ordered: directed cycle table, hand sequences for stall,
// backpressure and MAX_OUTSTANDING=1, then random traffic against a queue model.
module tb_rcn_master_ordered;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_vld, req_wr, rsp_rdy, mst_busy, mst_rdone, mst_wdone;
    logic [3:0]  req_mask, mst_rsp_mask;
    logic [23:0] req_addr, mst_rsp_addr;
    logic [31:0] req_wdata, mst_rsp_data;
    logic [1:0]  mst_rsp_seq;

    logic        req_rdy, rsp_vld, rsp_wr, stray_err, mst_cs, mst_wr;
    logic [3:0]  rsp_mask, mst_mask;
    logic [23:0] rsp_addr, mst_addr;
    logic [31:0] rsp_data, mst_wdata;
    logic [2:0]  outstanding;
    logic [1:0]  mst_seq;

    logic        d1_req_rdy, d1_rsp_vld, d1_rsp_wr, d1_stray_err, d1_mst_cs, d1_mst_wr;
    logic [3:0]  d1_rsp_mask, d1_mst_mask;
    logic [23:0] d1_rsp_addr, d1_mst_addr;
    logic [31:0] d1_rsp_data, d1_mst_wdata;
    logic [2:0]  d1_outstanding;
    logic [1:0]  d1_mst_seq;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rcn_master_ordered #(.MAX_OUTSTANDING(4)) dut (
        .clk(clk), .rst(rst), .req_vld(req_vld), .req_rdy(req_rdy), .req_wr(req_wr),
        .req_mask(req_mask), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_wr(rsp_wr), .rsp_mask(rsp_mask),
        .rsp_addr(rsp_addr), .rsp_data(rsp_data), .outstanding(outstanding),
        .stray_err(stray_err), .mst_cs(mst_cs), .mst_seq(mst_seq), .mst_busy(mst_busy),
        .mst_wr(mst_wr), .mst_mask(mst_mask), .mst_addr(mst_addr), .mst_wdata(mst_wdata),
        .mst_rdone(mst_rdone), .mst_wdone(mst_wdone), .mst_rsp_seq(mst_rsp_seq),
        .mst_rsp_mask(mst_rsp_mask), .mst_rsp_addr(mst_rsp_addr), .mst_rsp_data(mst_rsp_data)
    );

    rcn_master_ordered #(.MAX_OUTSTANDING(1)) dut1 (
        .clk(clk), .rst(rst), .req_vld(req_vld), .req_rdy(d1_req_rdy), .req_wr(req_wr),
        .req_mask(req_mask), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_vld(d1_rsp_vld), .rsp_rdy(rsp_rdy), .rsp_wr(d1_rsp_wr), .rsp_mask(d1_rsp_mask),
        .rsp_addr(d1_rsp_addr), .rsp_data(d1_rsp_data), .outstanding(d1_outstanding),
        .stray_err(d1_stray_err), .mst_cs(d1_mst_cs), .mst_seq(d1_mst_seq), .mst_busy(mst_busy),
        .mst_wr(d1_mst_wr), .mst_mask(d1_mst_mask), .mst_addr(d1_mst_addr), .mst_wdata(d1_mst_wdata),
        .mst_rdone(mst_rdone), .mst_wdone(mst_wdone), .mst_rsp_seq(mst_rsp_seq),
        .mst_rsp_mask(mst_rsp_mask), .mst_rsp_addr(mst_rsp_addr), .mst_rsp_data(mst_rsp_data)
    );

    typedef struct {
        logic        rst, vld, busy, rrdy, rd, wd;
        logic [1:0]  seq;
        logic [31:0] data;
        logic        e_rdy, e_cs;
        logic [1:0]  e_seq;
        logic        e_rvld;
        logic [31:0] e_rdata;
        logic [2:0]  e_out;
        logic        e_stray;
    } vec_t;

    typedef struct {
        logic [1:0]  seq;
        bit          got;
        logic        wr;
        logic [3:0]  mask;
        logic [23:0] addr;
        logic [31:0] data;
    } txn_t;

    vec_t tbl[$];
    txn_t q[$];

    function automatic vec_t mk(input logic r, v, b, rr, rd, wd, input logic [1:0] s,
                                input logic [31:0] d, input logic er, ec, input logic [1:0] es,
                                input logic ev, input logic [31:0] edata, input logic [2:0] eo,
                                input logic est);
        vec_t t;
        t = '{rst:r, vld:v, busy:b, rrdy:rr, rd:rd, wd:wd, seq:s, data:d, e_rdy:er, e_cs:ec,
              e_seq:es, e_rvld:ev, e_rdata:edata, e_out:eo, e_stray:est};
        return t;
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_vld = 0; req_wr = 0; req_mask = 4'hF; req_addr = 24'h000100; req_wdata = 0;
        rsp_rdy = 0; mst_busy = 0; mst_rdone = 0; mst_wdone = 0; mst_rsp_seq = 0;
        mst_rsp_mask = 0; mst_rsp_addr = 0; mst_rsp_data = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        tick();
        rst = 0;
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        tick();
        tick();
        rst = 0;

        //      rst v b rr rd wd seq data           rdy cs seq rvld rdata         out stray
        tbl.push_back(mk(0,0,1,0,0,0,0,0,            0,0,0,0,0,            0,0));
        tbl.push_back(mk(0,1,0,0,0,0,0,0,            1,1,0,0,0,            0,0));
        tbl.push_back(mk(0,0,0,0,1,0,0,32'hDEADBEEF, 1,0,1,0,0,            1,0));
        tbl.push_back(mk(0,0,0,1,0,0,0,0,            1,0,1,1,32'hDEADBEEF, 1,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,            1,0,1,0,0,            0,0));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,            1,0,0,0,0,            0,0));
        tbl.push_back(mk(0,1,0,0,0,0,0,0,            1,1,0,0,0,            0,0));
        tbl.push_back(mk(0,1,0,0,0,0,0,0,            1,1,1,0,0,            1,0));
        tbl.push_back(mk(0,1,0,0,0,0,0,0,            1,1,2,0,0,            2,0));
        tbl.push_back(mk(0,1,0,0,0,0,0,0,            1,1,3,0,0,            3,0));
        tbl.push_back(mk(0,1,0,0,1,0,2,32'hA2,       0,0,0,0,0,            4,0));
        tbl.push_back(mk(0,1,0,0,1,0,0,32'hA0,       0,0,0,0,0,            4,0));
        tbl.push_back(mk(0,1,0,0,1,0,3,32'hA3,       0,0,0,1,32'hA0,       4,0));
        tbl.push_back(mk(0,1,0,1,1,0,1,32'hA1,       0,0,0,1,32'hA0,       4,0));
        tbl.push_back(mk(0,1,0,1,0,0,0,0,            1,1,0,1,32'hA1,       3,0));
        tbl.push_back(mk(0,0,0,1,0,0,0,0,            1,0,1,1,32'hA2,       3,0));
        tbl.push_back(mk(0,0,0,1,0,0,0,0,            1,0,1,1,32'hA3,       2,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,            1,0,1,0,0,            1,0));
        tbl.push_back(mk(0,0,0,0,1,0,2,32'h77,       1,0,1,0,0,            1,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,            1,0,1,0,0,            1,1));
        tbl.push_back(mk(0,0,0,0,1,0,0,32'h55,       1,0,1,0,0,            1,1));
        tbl.push_back(mk(0,0,0,0,1,0,0,32'h99,       1,0,1,1,32'h55,       1,1));
        tbl.push_back(mk(0,0,0,1,0,0,0,0,            1,0,1,1,32'h55,       1,1));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,            1,0,1,0,0,            0,1));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,            1,0,0,0,0,            0,0));
        tbl.push_back(mk(0,0,0,0,1,0,3,32'h33,       1,0,0,0,0,            0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,            1,0,0,0,0,            0,1));

        foreach (tbl[i]) begin
            rst = tbl[i].rst; req_vld = tbl[i].vld; mst_busy = tbl[i].busy; rsp_rdy = tbl[i].rrdy;
            mst_rdone = tbl[i].rd; mst_wdone = tbl[i].wd; mst_rsp_seq = tbl[i].seq;
            mst_rsp_data = tbl[i].data;
            #1;
            chk($sformatf("tbl%0d_req_rdy", i), 64'(req_rdy), 64'(tbl[i].e_rdy));
            chk($sformatf("tbl%0d_mst_cs", i), 64'(mst_cs), 64'(tbl[i].e_cs));
            chk($sformatf("tbl%0d_mst_seq", i), 64'(mst_seq), 64'(tbl[i].e_seq));
            chk($sformatf("tbl%0d_rsp_vld", i), 64'(rsp_vld), 64'(tbl[i].e_rvld));
            if (tbl[i].e_rvld || tbl[i].rst)
                chk($sformatf("tbl%0d_rsp_data", i), 64'(rsp_data), 64'(tbl[i].e_rdata));
            chk($sformatf("tbl%0d_outstanding", i), 64'(outstanding), 64'(tbl[i].e_out));
            chk($sformatf("tbl%0d_stray", i), 64'(stray_err), 64'(tbl[i].e_stray));
            tick();
        end

        // mst_busy stall, then a single issue on release
        do_reset();
        req_vld = 1; mst_busy = 1;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("stall_req_rdy", 64'(req_rdy), 64'(0));
            chk("stall_outstanding", 64'(outstanding), 64'(0));
            chk("stall_mst_seq", 64'(mst_seq), 64'(0));
            tick();
        end
        mst_busy = 0;
        #1;
        chk("release_req_rdy", 64'(req_rdy), 64'(1));
        tick();
        req_vld = 0;
        #1;
        chk("release_outstanding", 64'(outstanding), 64'(1));
        chk("release_mst_seq", 64'(mst_seq), 64'(1));

        // response backpressure with a concurrent new issue
        req_vld = 1;
        tick();
        req_vld = 0;
        mst_wdone = 1; mst_rsp_seq = 0; mst_rsp_mask = 4'h3;
        mst_rsp_addr = 24'h123456; mst_rsp_data = 32'hCAFEF00D;
        tick();
        mst_wdone = 0; mst_rsp_data = 32'h0; mst_rsp_addr = 24'h0; mst_rsp_mask = 4'h0;
        rsp_rdy = 0;
        for (int c = 0; c < 5; c++) begin
            req_vld = (c == 0);
            #1;
            chk("bp_rsp_vld", 64'(rsp_vld), 64'(1));
            chk("bp_rsp_wr", 64'(rsp_wr), 64'(1));
            chk("bp_rsp_mask", 64'(rsp_mask), 64'(4'h3));
            chk("bp_rsp_addr", 64'(rsp_addr), 64'(24'h123456));
            chk("bp_rsp_data", 64'(rsp_data), 64'(32'hCAFEF00D));
            chk("bp_outstanding", 64'(outstanding), 64'((c == 0) ? 2 : 3));
            tick();
        end
        req_vld = 0; rsp_rdy = 1;
        tick();
        rsp_rdy = 0;
        #1;
        chk("bp_after_retire", 64'(outstanding), 64'(2));

        // MAX_OUTSTANDING=1 instance
        do_reset();
        req_vld = 1;
        #1;
        chk("m1_first_rdy", 64'(d1_req_rdy), 64'(1));
        chk("m1_first_seq", 64'(d1_mst_seq), 64'(0));
        tick();
        #1;
        chk("m1_block_rdy", 64'(d1_req_rdy), 64'(0));
        chk("m1_block_cs", 64'(d1_mst_cs), 64'(0));
        chk("m1_block_out", 64'(d1_outstanding), 64'(1));
        tick();
        mst_rdone = 1; mst_rsp_seq = 0; mst_rsp_data = 32'h1111;
        tick();
        mst_rdone = 0; rsp_rdy = 1;
        #1;
        chk("m1_rsp_vld", 64'(d1_rsp_vld), 64'(1));
        chk("m1_rsp_data", 64'(d1_rsp_data), 64'(32'h1111));
        chk("m1_retire_cycle_rdy", 64'(d1_req_rdy), 64'(0));
        tick();
        rsp_rdy = 0;
        #1;
        chk("m1_next_rdy", 64'(d1_req_rdy), 64'(1));
        chk("m1_next_cs", 64'(d1_mst_cs), 64'(1));
        chk("m1_next_seq", 64'(d1_mst_seq), 64'(1));
        chk("m1_next_out", 64'(d1_outstanding), 64'(0));
        for (int c = 0; c < 40; c++) begin
            req_vld = 1'($urandom_range(0, 1)); rsp_rdy = 1'($urandom_range(0, 1));
            mst_rdone = 1'($urandom_range(0, 1)); mst_rsp_seq = 2'($urandom);
            #1;
            chk("m1_bound", 64'(d1_outstanding <= 3'd1), 64'(1));
            tick();
        end

        // random traffic against an in-order queue model
        do_reset();
        begin
            int    nissued = 0;
            bit    mstray  = 0;
            bit    e_rdy, e_rvld, do_issue, do_retire;
            int    pend[$];
            int    k, hit;
            for (int c = 0; c < 600; c++) begin
                req_vld = ($urandom_range(0, 3) != 0); mst_busy = ($urandom_range(0, 3) == 0);
                rsp_rdy = ($urandom_range(0, 2) != 0); req_wr = 1'($urandom);
                req_mask = 4'($urandom); req_addr = 24'($urandom); req_wdata = $urandom;
                mst_rdone = 0; mst_wdone = 0;
                mst_rsp_seq = 2'($urandom); mst_rsp_mask = 4'($urandom);
                mst_rsp_addr = 24'($urandom); mst_rsp_data = $urandom;
                pend.delete();
                foreach (q[j]) if (!q[j].got) pend.push_back(j);
                if (pend.size() > 0 && $urandom_range(0, 1) == 1) begin
                    k = pend[$urandom_range(0, pend.size() - 1)];
                    mst_rsp_seq = q[k].seq;
                    case ($urandom_range(0, 2))
                        0:       mst_rdone = 1;
                        1:       mst_wdone = 1;
                        default: begin mst_rdone = 1; mst_wdone = 1; end
                    endcase
                end else if ($urandom_range(0, 19) == 0) begin
                    mst_rdone = 1;
                end
                e_rdy  = (q.size() < 4) && !mst_busy;
                e_rvld = (q.size() > 0) && q[0].got;
                #1;
                chk("rnd_req_rdy", 64'(req_rdy), 64'(e_rdy));
                chk("rnd_mst_cs", 64'(mst_cs), 64'(req_vld && (q.size() < 4)));
                chk("rnd_mst_seq", 64'(mst_seq), 64'(nissued % 4));
                chk("rnd_mst_addr", 64'(mst_addr), 64'(req_addr));
                chk("rnd_outstanding", 64'(outstanding), 64'(q.size()));
                chk("rnd_stray", 64'(stray_err), 64'(mstray));
                chk("rnd_rsp_vld", 64'(rsp_vld), 64'(e_rvld));
                if (e_rvld) begin
                    chk("rnd_rsp_data", 64'(rsp_data), 64'(q[0].data));
                    chk("rnd_rsp_meta", 64'({rsp_wr, rsp_mask, rsp_addr}),
                        64'({q[0].wr, q[0].mask, q[0].addr}));
                end
                do_issue  = req_vld && e_rdy;
                do_retire = e_rvld && rsp_rdy;
                if (mst_rdone || mst_wdone) begin
                    hit = -1;
                    foreach (q[j]) if (q[j].seq == mst_rsp_seq && !q[j].got) hit = j;
                    if (hit < 0) mstray = 1;
                    else begin
                        q[hit].got  = 1;
                        q[hit].wr   = mst_wdone;
                        q[hit].mask = mst_rsp_mask;
                        q[hit].addr = mst_rsp_addr;
                        q[hit].data = mst_rsp_data;
                    end
                end
                if (do_retire) void'(q.pop_front());
                if (do_issue) begin
                    q.push_back('{seq: 2'(nissued % 4), got: 0, wr: 0, mask: 0, addr: 0, data: 0});
                    nissued++;
                end
                tick();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
